// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 16x16 multiply / 16/16 divide unit.
// A multiply uses 16 shift-add steps. A divide uses 16 restoring
// shift-subtract steps. Each step takes one clock cycle.
// Signed operations work on magnitudes and fix up the signs at the end.
// The result registers hold their value until the next completion.

module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic        write_lo,
    output logic        write_hi,
    output logic [15:0] value_lo,
    output logic [15:0] value_hi,
    output logic        negative,
    output logic        overflow,
    output logic        carry,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  op_reg;
    // hi_reg: partial product high half, or partial remainder.
    // lo_reg: multiplier being shifted out, or dividend/quotient.
    logic [15:0] hi_reg;
    logic [15:0] lo_reg;
    logic [15:0] opnd_reg;      // multiplicand magnitude or divisor magnitude
    logic [15:0] raw_a_reg;     // unmodified dividend, returned on divide by zero
    logic [4:0]  count_reg;
    logic        neg_q_reg;     // negate product / quotient at the end
    logic        neg_r_reg;     // negate remainder at the end
    logic        div0_reg;
    logic        ovf_min_reg;   // signed 0x8000 / -1 case

    // Operand magnitudes for the request being accepted
    logic        req_signed;
    logic [15:0] abs_a;
    logic [15:0] abs_b;

    // Accept-side sign handling
    always_comb begin
        req_signed = op[0];
        abs_a      = (req_signed && operand_a[15]) ? (~operand_a + 16'd1) : operand_a;
        abs_b      = (req_signed && operand_b[15]) ? (~operand_b + 16'd1) : operand_b;
    end

    // One iteration step for each kind of operation
    logic [16:0] mul_sum;
    logic [16:0] div_trial;
    logic [15:0] step_hi;
    logic [15:0] step_lo;

    // Shift-add or restoring shift-subtract step
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : 17'd0);
        div_trial = {hi_reg, lo_reg[15]} - {1'b0, opnd_reg};
        step_hi   = hi_reg;
        step_lo   = lo_reg;
        if (op_reg[1]) begin
            if (!div_trial[16]) begin
                step_hi = div_trial[15:0];
                step_lo = {lo_reg[14:0], 1'b1};
            end else begin
                step_hi = {hi_reg[14:0], lo_reg[15]};
                step_lo = {lo_reg[14:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[16:1];
            step_lo = {mul_sum[0], lo_reg[15:1]};
        end
    end

    // Final result after sign correction, plus the status flags
    logic [31:0] prod_raw;
    logic [31:0] prod_fix;
    logic [15:0] quo_fix;
    logic [15:0] rem_fix;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic        res_n;
    logic        res_v;
    logic        res_c;
    logic        res_z;

    // Result selection and flag generation
    always_comb begin
        prod_raw = {hi_reg, lo_reg};
        prod_fix = neg_q_reg ? (~prod_raw + 32'd1) : prod_raw;
        quo_fix  = neg_q_reg ? (~lo_reg + 16'd1) : lo_reg;
        rem_fix  = neg_r_reg ? (~hi_reg + 16'd1) : hi_reg;
        res_lo   = 16'h0000;
        res_hi   = 16'h0000;
        res_n    = 1'b0;
        res_v    = 1'b0;
        res_c    = 1'b0;
        res_z    = 1'b0;
        if (op_reg[1]) begin
            if (div0_reg) begin
                res_lo = 16'hFFFF;
                res_hi = raw_a_reg;
                res_v  = 1'b1;
            end else begin
                res_lo = quo_fix;
                res_hi = rem_fix;
                res_v  = ovf_min_reg;
            end
            res_n = res_lo[15];
            res_z = (res_lo == 16'h0000);
        end else begin
            res_lo = prod_fix[15:0];
            res_hi = prod_fix[31:16];
            res_n  = res_hi[15];
            res_z  = (prod_fix == 32'd0);
            res_c  = !op_reg[0] && (res_hi != 16'h0000);
            res_v  = op_reg[0] && (res_hi != {16{res_lo[15]}});
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            op_reg      <= 2'b00;
            hi_reg      <= 16'h0000;
            lo_reg      <= 16'h0000;
            opnd_reg    <= 16'h0000;
            raw_a_reg   <= 16'h0000;
            count_reg   <= 5'd0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            div0_reg    <= 1'b0;
            ovf_min_reg <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            write_lo    <= 1'b0;
            write_hi    <= 1'b0;
            value_lo    <= 16'h0000;
            value_hi    <= 16'h0000;
            negative    <= 1'b0;
            overflow    <= 1'b0;
            carry       <= 1'b0;
            zero        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done     <= 1'b0;
                    write_lo <= 1'b0;
                    write_hi <= 1'b0;
                    if (start) begin
                        state_reg   <= CALC;
                        busy        <= 1'b1;
                        op_reg      <= op;
                        count_reg   <= 5'd0;
                        hi_reg      <= 16'h0000;
                        raw_a_reg   <= operand_a;
                        div0_reg    <= op[1] && (operand_b == 16'h0000);
                        ovf_min_reg <= (op == 2'b11) && (operand_a == 16'h8000)
                                       && (operand_b == 16'hFFFF);
                        neg_q_reg   <= req_signed && (operand_a[15] ^ operand_b[15]);
                        neg_r_reg   <= req_signed && op[1] && operand_a[15];
                        if (op[1]) begin
                            lo_reg   <= abs_a;
                            opnd_reg <= abs_b;
                        end else begin
                            lo_reg   <= abs_b;
                            opnd_reg <= abs_a;
                        end
                    end
                end
                CALC: begin
                    // A divide by zero has no iteration steps
                    if (div0_reg || (count_reg == 5'd16)) begin
                        state_reg <= FINISH;
                        done      <= 1'b1;
                        write_lo  <= 1'b1;
                        write_hi  <= 1'b1;
                        value_lo  <= res_lo;
                        value_hi  <= res_hi;
                        negative  <= res_n;
                        overflow  <= res_v;
                        carry     <= res_c;
                        zero      <= res_z;
                    end else begin
                        hi_reg    <= step_hi;
                        lo_reg    <= step_lo;
                        count_reg <= count_reg + 5'd1;
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    write_lo  <= 1'b0;
                    write_hi  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    write_lo  <= 1'b0;
                    write_hi  <= 1'b0;
                end
            endcase
        end
    end

endmodule
